dff_pipe: RTL
=============

DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, data width in bits (legal range 1..64).
REQ-002 The module SHALL have parameter DEPTH, default 4, number of register stages (legal range 1..16).
REQ-003 The module SHALL have parameter RESET_VAL, default 0, WIDTH-bit reset value of every data stage.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port D  input  WIDTH  data into stage 0.
REQ-007 Port in_valid  input  1  D carries a valid word this cycle.
REQ-008 Port en  input  1  advance; pipeline shifts one stage when high, holds when low.
REQ-009 Port flush  input  1  synchronous invalidate of all stages.
REQ-010 Port Q  output  WIDTH  data register of the last stage (stage DEPTH-1).
REQ-011 Port out_valid  output  1  valid bit of the last stage.
REQ-012 Port occupancy  output  $clog2(DEPTH+1)  count of valid stages.
REQ-013 Port parity_err  output  1  sticky parity error flag (see Configuration).

Function
REQ-014 On a clk edge with en=1, stage 0 SHALL load D/in_valid and stage i SHALL load stage i-1 for i=1..DEPTH-1.
REQ-015 On a clk edge with en=0, all data and valid registers SHALL hold.
REQ-016 Latency SHALL be exactly DEPTH en-high edges from D sampled to Q; en-low cycles add no data loss.
REQ-017 Q SHALL be a register output with no combinational path from D, en or flush.
REQ-018 Data registers SHALL shift per REQ-014 regardless of valid bits; invalid words still propagate.
REQ-019 flush=1 SHALL clear every valid bit at the next edge, overriding en and in_valid; data registers SHALL follow REQ-014/015 unchanged.
REQ-020 occupancy SHALL be a registered counter: flush -> 0; else en=1 -> occupancy + in_valid - valid[DEPTH-1]; else hold.
REQ-021 occupancy SHALL equal the population count of the valid bits after every edge, and never exceed DEPTH.
REQ-022 With DEPTH=1, stage 0 SHALL be the last stage; in_valid and valid[0] both high with en=1 SHALL leave occupancy at 1.

Reset
REQ-023 While rst=1, every data stage SHALL equal RESET_VAL, every valid bit 0, occupancy 0, parity_err 0, independent of clk.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight words; the first en-high edge after rst deasserts SHALL load stage 0 normally.

Configuration
REQ-025 Macro DFF_PIPE_PARITY_EN defined: each stage SHALL carry an extra bit holding even parity (XOR) of D computed at stage 0, shifted with the data.
REQ-026 With DFF_PIPE_PARITY_EN: parity_err SHALL set on an edge where out_valid=1 and XOR(Q) differs from the last-stage parity bit; cleared only by rst or flush.
REQ-027 Without DFF_PIPE_PARITY_EN: no parity storage SHALL exist and parity_err SHALL be constant 0.

Structure
REQ-028 Package dff_pipe_pkg SHALL hold default WIDTH/DEPTH constants and the even-parity function.
REQ-029 One stage (data, valid, optional parity, enable) SHALL be sub-module dff_pipe_stage, instantiated DEPTH times via generate.

Verification
REQ-030 Reset: rst pulse 1 ns wide between edges, RESET_VAL=4'h0 -> Q=0, out_valid=0, occupancy=0 immediately, no clk needed.
REQ-031 Stream: WIDTH=4, DEPTH=4, en=1, in_valid=1, D=1,2,3,... -> Q=1 on 4th edge after first sample, then 2,3,...; occupancy 1,2,3,4,4.
REQ-032 Stall: during stream hold en=0 for 3 cycles -> Q, out_valid, occupancy frozen; resumes with no lost or duplicated word vs. reference queue.
REQ-033 Flush: pipe full (occupancy=4), flush=1 with en=1, in_valid=1 -> next edge out_valid=0, occupancy=0; following words emerge after full latency.
REQ-034 Bubbles: random in_valid and en over 1000 cycles -> occupancy equals popcount of valid bits every cycle; valid words out match a queue model in order.
REQ-035 Parity (macro defined): force last-stage data bit 0 flip while out_valid=1 -> parity_err=1 next edge, stays 1 until flush.

Source files
------------

// File: rtl/dff_pipe_pkg.sv
// Shared constants and the even-parity helper for the dff_pipe slice.
package dff_pipe_pkg;

    localparam int DFF_PIPE_WIDTH_DEF = 4;
    localparam int DFF_PIPE_DEPTH_DEF = 4;
    localparam int DFF_PIPE_MAX_WIDTH = 64;

    // Callers zero-extend their word; extra zero bits do not change the XOR.
    function automatic logic even_parity(input logic [DFF_PIPE_MAX_WIDTH-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline stage: data, valid and (with DFF_PIPE_PARITY_EN) a parity bit,
// all advancing on en; flush clears only the valid bit.
module dff_pipe_stage #(
    parameter int              WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
`ifdef DFF_PIPE_PARITY_EN
    input  logic             par_i,
    output logic             par_o,
`endif
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= RESET_VAL;
        end else if (en) begin
            data_q <= data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (en) begin
            valid_q <= valid_i;
        end
    end

`ifdef DFF_PIPE_PARITY_EN
    logic par_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else if (en) begin
            par_q <= par_i;
        end
    end

    assign par_o = par_q;
`endif

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/dff_pipe.sv
// Enable-gated register pipeline with valid tracking and an occupancy counter.
// Optional stored parity with a sticky error flag: define DFF_PIPE_PARITY_EN.
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int               WIDTH     = DFF_PIPE_WIDTH_DEF,
    parameter int               DEPTH     = DFF_PIPE_DEPTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           D,
    input  logic                       in_valid,
    input  logic                       en,
    input  logic                       flush,
    output logic [WIDTH-1:0]           Q,
    output logic                       out_valid,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       parity_err
);

    localparam int OCC_W = $clog2(DEPTH+1);
    localparam int LAST  = DEPTH - 1;

    logic [WIDTH-1:0] data_w  [DEPTH];
    logic             valid_w [DEPTH];
    logic [WIDTH-1:0] stg_data_in  [DEPTH];
    logic             stg_valid_in [DEPTH];
`ifdef DFF_PIPE_PARITY_EN
    logic             par_w        [DEPTH];
    logic             stg_par_in   [DEPTH];
`endif

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign stg_data_in[gi]  = D;
                assign stg_valid_in[gi] = in_valid;
`ifdef DFF_PIPE_PARITY_EN
                assign stg_par_in[gi]   = even_parity(DFF_PIPE_MAX_WIDTH'(D));
`endif
            end else begin : g_body
                assign stg_data_in[gi]  = data_w[gi-1];
                assign stg_valid_in[gi] = valid_w[gi-1];
`ifdef DFF_PIPE_PARITY_EN
                assign stg_par_in[gi]   = par_w[gi-1];
`endif
            end

            dff_pipe_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .en      (en),
                .flush   (flush),
                .data_i  (stg_data_in[gi]),
                .valid_i (stg_valid_in[gi]),
`ifdef DFF_PIPE_PARITY_EN
                .par_i   (stg_par_in[gi]),
                .par_o   (par_w[gi]),
`endif
                .data_o  (data_w[gi]),
                .valid_o (valid_w[gi])
            );
        end
    endgenerate

    // Counter tracks valid bits incrementally: one may enter and one may leave per shift.
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (en) begin
            occ_d = occ_q + OCC_W'(in_valid) - OCC_W'(valid_w[LAST]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

`ifdef DFF_PIPE_PARITY_EN
    logic perr_q;
    logic perr_d;

    always_comb begin
        perr_d = perr_q;
        if (flush) begin
            perr_d = 1'b0;
        end else if (valid_w[LAST] &&
                     (even_parity(DFF_PIPE_MAX_WIDTH'(data_w[LAST])) != par_w[LAST])) begin
            perr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign Q         = data_w[LAST];
    assign out_valid = valid_w[LAST];
    assign occupancy = occ_q;

endmodule
